// File: rtl/ps_frame_loader_if.sv
// Bundles the PS word strobe side and the frame-RAM write side of the loader.
interface ps_frame_loader_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 9
);
  logic              en;
  logic [DATA_W-1:0] voltage_data;
  logic [ADDR_W-1:0] phi_number;
  logic              ready;
  logic              ram_wr_clk;
  logic              ram_wr_en;
  logic [ADDR_W:0]   ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;

  modport master (
    output en, voltage_data, phi_number,
    input  ready, ram_wr_clk, ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  en, voltage_data, phi_number,
    output ready, ram_wr_clk, ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/ps_frame_loader.sv
// Collects one frame of PS voltage words into a double-buffered RAM and swaps
// banks when the frame is complete; an over-long idle gap aborts the frame.
module ps_frame_loader #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 9,
  parameter int N_ELEM = 480,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  ps_frame_loader_if.slave  bus,
  input  logic [TMO_W-1:0]  timeout_limit,
  input  logic              err_clr,
  output logic              send,
  output logic              rd_bank,
  output logic              busy,
  output logic [ADDR_W:0]   words_loaded,
  output logic              err_range,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ABORT} state_t;

  localparam logic [ADDR_W:0] N_LAST = (ADDR_W+1)'(N_ELEM);

  state_t             state;
  logic               wr_bank;
  logic               ready_reg;
  logic [TMO_W-1:0]   gap;
  logic [TMO_W-1:0]   gap_inc;
  logic [ADDR_W:0]    wl_inc;
  logic               in_range;
  logic               accept;
  logic               oor;

  // Widened compare so N_ELEM = 2^ADDR_W still works.
  assign in_range = {1'b0, bus.phi_number} < N_LAST;
  assign accept   = bus.en && ready_reg && in_range;
  assign oor      = bus.en && ready_reg && !in_range;
  assign gap_inc  = gap + TMO_W'(1);
  assign wl_inc   = words_loaded + (ADDR_W+1)'(1);

  assign bus.ready      = ready_reg;
  assign bus.ram_wr_clk = clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wr_bank         <= 1'b0;
      rd_bank         <= 1'b1;
      ready_reg       <= 1'b1;
      busy            <= 1'b0;
      send            <= 1'b0;
      gap             <= '0;
      words_loaded    <= '0;
      err_range       <= 1'b0;
      err_timeout     <= 1'b0;
      bus.ram_wr_en   <= 1'b0;
      bus.ram_wr_addr <= '0;
      bus.ram_wr_data <= '0;
    end else begin
      bus.ram_wr_en <= 1'b0;
      send          <= 1'b0;

      if (accept) begin
        bus.ram_wr_en   <= 1'b1;
        bus.ram_wr_addr <= {wr_bank, bus.phi_number};
        bus.ram_wr_data <= bus.voltage_data;
      end

      // A set event in the same cycle as err_clr takes priority.
      if (oor)
        err_range <= 1'b1;
      else if (err_clr)
        err_range <= 1'b0;

      if (state == ABORT)
        err_timeout <= 1'b1;
      else if (err_clr)
        err_timeout <= 1'b0;

      case (state)
        IDLE: begin
          gap <= '0;
          if (accept) begin
            words_loaded <= (ADDR_W+1)'(1);
            if (N_ELEM == 1) begin
              state     <= DONE;
              ready_reg <= 1'b0;
            end else begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (accept)
            words_loaded <= wl_inc;
          if (accept && wl_inc == N_LAST) begin
            state     <= DONE;
            ready_reg <= 1'b0;
            busy      <= 1'b0;
            gap       <= '0;
          end else if (bus.en) begin
            gap <= '0;
          end else if (timeout_limit != '0 && gap_inc >= timeout_limit) begin
            state     <= ABORT;
            ready_reg <= 1'b0;
            busy      <= 1'b0;
            gap       <= '0;
          end else begin
            gap <= gap_inc;
          end
        end

        DONE: begin
          send         <= 1'b1;
          rd_bank      <= wr_bank;
          wr_bank      <= ~wr_bank;
          words_loaded <= '0;
          state        <= IDLE;
          ready_reg    <= 1'b1;
        end

        ABORT: begin
          words_loaded <= '0;
          state        <= IDLE;
          ready_reg    <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          ready_reg <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
